bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shares one external 32-bit request/ready memory bus between the pipeline's instruction-fetch port and its data (load/store) port.
//  Sits between the pipeline and the bus fabric. Produces fetch_ready/mem_ready for hazard stalling, and performs byte-lane steering and load extension.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive data grants allowed while fetch waits (only with BUS_ARB_FAIR_EN)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  reset           in   1   asynchronous, active-low reset
//  fetch_address   in   32  instruction address; request implicit every cycle
//  fetch_data      out  32  instruction word, valid while fetch_ready=1
//  fetch_ready     out  1   one-cycle pulse: fetch_data belongs to current fetch_address
//  mem_address     in   32  data byte address
//  mem_store_data  in   32  store data, right-aligned
//  mem_size        in   2   0=byte 1=half 2=word
//  mem_signed      in   1   sign-extend load
//  mem_load        in   1   load request (level)
//  mem_store       in   1   store request (level); never together with mem_load
//  mem_load_data   out  32  extended load result, valid while mem_ready=1
//  mem_ready       out  1   1 when no data request, else one-cycle completion pulse
//  ext_address     out  32  word address {addr[31:2],2'b00}
//  ext_write_data  out  32  lane-replicated store data
//  ext_strobe      out  4   byte write enables (0 on reads)
//  ext_write       out  1   1=write 0=read, qualified by ext_valid
//  ext_valid       out  1   request; held with stable fields until ext_ready
//  ext_ready       in   1   completion; ext_read_data valid same cycle
//  ext_read_data   in   32  raw read word
// BEHAVIOUR
//  Reset values: ext_valid=0, ext_write=0, ext_strobe=0, ext_address=0, ext_write_data=0, fetch_ready=0, fetch_data=0, mem_load_data=0.
//  mem_ready = ~(mem_load|mem_store) during reset.
//  FSM: IDLE -> BUS (ext_valid=1) -> RESP -> IDLE. All ext_* outputs are registered.
//  IDLE: grant data if mem_load|mem_store, else grant fetch.
//   Latch the address, the size/signed/lane fields and the granted owner. Next cycle: BUS.
//  BUS: hold all fields until ext_ready. On ext_ready, register the read word. Drop ext_valid. Go to RESP.
//  RESP: one-cycle response.
//   Data owner: mem_ready=1 with mem_load_data.
//   Fetch owner: fetch_ready=1 only if latched address == current fetch_address. Otherwise the word is silently discarded (branch/trap redirect).
//   Always returns to IDLE. Requests present in RESP are not re-issued; a new request is sampled in IDLE.
//  Zero-wait latency: request seen in IDLE cycle N; ext_valid in N+1; ready pulse in N+2.
//  Lane rules use the latched addr[1:0]:
//   byte: strobe = 1<<a, data = {4{d[7:0]}}
//   half: strobe = 0011<<a[1]*2, data = {2{d[15:0]}}
//   word: strobe = 1111
//   Loads shift right by a*8, then zero- or sign-extend from bit 7/15.
//  Misaligned access: addr bits below natural alignment are ignored (half uses a[1] only, word uses none).
//  Size 3 is treated as word.
//  Fetch is always word, read-only, strobe 0.
//  mem_ready is combinational: ~(mem_load|mem_store) | resp_data_pulse. fetch_ready is registered-pulse AND address compare.
//  Reset asserted mid-transaction: ext_valid drops immediately and no ready pulse is produced. The slave must tolerate an abandoned request.
// CONFIGURATION
//  BUS_ARB_FAIR_EN defined:
//   A saturating counter counts data grants issued while fetch was also pending (fetch is always pending).
//   When the count reaches STARVE_LIMIT, the next IDLE grants fetch and the counter clears.
//   Any fetch grant also clears it.
//  BUS_ARB_FAIR_EN undefined: strict data priority, no counter logic.
// STRUCTURE
//  bus_pkg:
//   typedef enum arb_state_t {IDLE,BUS,RESP}
//   typedef enum owner_t {OWN_FETCH,OWN_DATA}
//   constants SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2
//  Sub-module bus_lane_align (combinational): store replication + strobe generation, load shift + extension. Instantiated once.
// TESTING
//  1. Fetch only, ext_ready tied 1, fetch_address=0x100: ext_valid at N+1 with ext_address=0x100; fetch_ready pulse at N+2 with fetch_data=ext word.
//  2. mem_load and fetch both pending in IDLE: data granted first. mem_ready=0 until the pulse, then the fetch transaction follows.
//  3. Load byte signed at 0x203, ext_read_data=0x80FFFFFF: mem_load_data=0xFFFFFF80. Unsigned half at 0x202, data 0x8001xxxx: 0x00008001.
//  4. Store half at 0x206, mem_store_data=0x1234ABCD: ext_address=0x204, ext_strobe=1100, ext_write_data=0xABCDABCD, ext_write=1.
//  5. Fetch at 0x40 with ext_ready delayed 3 cycles; fetch_address changes to 0x80 meanwhile: no fetch_ready for 0x40, new request to 0x80 issued.
//  6. Reset deasserted to asserted while in BUS: ext_valid=0 the same cycle, no ready pulses. With BUS_ARB_FAIR_EN and constant mem_load: every 5th grant is fetch.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the fetch/data bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/bus_arbiter_if.sv
// External request/ready memory bus seen by the arbiter (master side).
interface bus_arbiter_if;

    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  strobe;
    logic        write;
    logic        valid;
    logic        ready;
    logic [31:0] read_data;

    modport master (
        output address, write_data, strobe, write, valid,
        input  ready, read_data
    );

    modport slave (
        input  address, write_data, strobe, write, valid,
        output ready, read_data
    );

endinterface

// File: rtl/bus_arbiter_align.sv
// Byte-lane steering: store replication/strobes and load shift/extension.
module bus_lane_align
    import bus_pkg::*;
(
    input  logic [1:0]  st_lane,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic [3:0]  st_strobe,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_lane,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_strobe = 4'b1111;
        st_wdata  = st_data;
        case (st_size)
            SIZE_BYTE: begin
                st_strobe = 4'b0001 << st_lane;
                st_wdata  = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                st_strobe = st_lane[1] ? 4'b1100 : 4'b0011;
                st_wdata  = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Half loads only honour a[1]; size 3 falls through as word.
    always_comb begin
        ld_byte = ld_raw[{ld_lane, 3'b000} +: 8];
        ld_half = ld_raw[{ld_lane[1], 4'b0000} +: 16];
        ld_data = ld_raw;
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Fetch/data arbiter onto one request/ready bus with lane steering.
// Optional fetch anti-starvation under `define BUS_ARB_FAIR_EN.
module bus_arbiter
    import bus_pkg::*;
`ifdef BUS_ARB_FAIR_EN
#(
    parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_address,
    output logic [31:0] fetch_data,
    output logic        fetch_ready,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_store_data,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic        mem_load,
    input  logic        mem_store,
    output logic [31:0] mem_load_data,
    output logic        mem_ready,
    bus_arbiter_if.master ext
);

    arb_state_t  state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] rdata_q, rdata_d;
    logic        valid_q, valid_d;
    logic [31:0] eaddr_q, eaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strobe_q, strobe_d;
    logic        write_q, write_d;
    logic        mem_req, grant_data;
    logic [3:0]  st_strobe;
    logic [31:0] st_wdata;

`ifdef BUS_ARB_FAIR_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    assign mem_req = mem_load | mem_store;

    bus_lane_align u_align (
        .st_lane   (mem_address[1:0]),
        .st_size   (mem_size),
        .st_data   (mem_store_data),
        .st_strobe (st_strobe),
        .st_wdata  (st_wdata),
        .ld_lane   (addr_q[1:0]),
        .ld_size   (size_q),
        .ld_signed (sgn_q),
        .ld_raw    (rdata_q),
        .ld_data   (mem_load_data)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        rdata_d    = rdata_q;
        valid_d    = valid_q;
        eaddr_d    = eaddr_q;
        wdata_d    = wdata_q;
        strobe_d   = strobe_q;
        write_d    = write_q;
        grant_data = mem_req;
`ifdef BUS_ARB_FAIR_EN
        cnt_d = cnt_q;
        if (cnt_q >= LIMIT) grant_data = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                state_d = BUS;
                valid_d = 1'b1;
                if (grant_data) begin
                    owner_d  = OWN_DATA;
                    addr_d   = mem_address;
                    size_d   = mem_size;
                    sgn_d    = mem_signed;
                    eaddr_d  = {mem_address[31:2], 2'b00};
                    wdata_d  = st_wdata;
                    strobe_d = mem_store ? st_strobe : 4'b0000;
                    write_d  = mem_store;
                end else begin
                    owner_d  = OWN_FETCH;
                    addr_d   = fetch_address;
                    size_d   = SIZE_WORD;
                    sgn_d    = 1'b0;
                    eaddr_d  = {fetch_address[31:2], 2'b00};
                    wdata_d  = '0;
                    strobe_d = 4'b0000;
                    write_d  = 1'b0;
                end
`ifdef BUS_ARB_FAIR_EN
                if (!grant_data) cnt_d = '0;
                else if (cnt_q < LIMIT) cnt_d = cnt_q + 1'b1;
`endif
            end
            BUS: begin
                if (ext.ready) begin
                    rdata_d = ext.read_data;
                    valid_d = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_FETCH;
            addr_q   <= '0;
            size_q   <= SIZE_BYTE;
            sgn_q    <= 1'b0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            eaddr_q  <= '0;
            wdata_q  <= '0;
            strobe_q <= '0;
            write_q  <= 1'b0;
`ifdef BUS_ARB_FAIR_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            eaddr_q  <= eaddr_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
            write_q  <= write_d;
`ifdef BUS_ARB_FAIR_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign ext.valid      = valid_q;
    assign ext.address    = eaddr_q;
    assign ext.write_data = wdata_q;
    assign ext.strobe     = strobe_q;
    assign ext.write      = write_q;

    // A fetch word is dropped if the pipeline redirected meanwhile.
    assign fetch_data  = rdata_q;
    assign fetch_ready = (state_q == RESP) && (owner_q == OWN_FETCH)
                         && (addr_q == fetch_address);
    assign mem_ready   = ~mem_req
                         | ((state_q == RESP) && (owner_q == OWN_DATA));

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: transaction model plus directed cases.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] fetch_address = 32'h100;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic [31:0] mem_address = 32'h0;
    logic [31:0] mem_store_data = 32'h0;
    logic [1:0]  mem_size = 2'd0;
    logic        mem_signed = 1'b0;
    logic        mem_load = 1'b0;
    logic        mem_store = 1'b0;
    logic [31:0] mem_load_data;
    logic        mem_ready;
    logic [31:0] rd_word = 32'hDEADBEEF;
    int          wait_n = 0;
    int          vcnt = 0;
    int          tests = 0;
    int          fails = 0;

    bus_arbiter_if ext();

    assign ext.ready     = ext.valid && (vcnt >= wait_n);
    assign ext.read_data = rd_word;

    bus_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_address  (fetch_address),
        .fetch_data     (fetch_data),
        .fetch_ready    (fetch_ready),
        .mem_address    (mem_address),
        .mem_store_data (mem_store_data),
        .mem_size       (mem_size),
        .mem_signed     (mem_signed),
        .mem_load       (mem_load),
        .mem_store      (mem_store),
        .mem_load_data  (mem_load_data),
        .mem_ready      (mem_ready),
        .ext            (ext)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        vcnt <= (ext.valid && !ext.ready) ? vcnt + 1 : 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        bit          data;
        bit          store;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] sdata;
    } txn_t;

    function automatic logic [3:0] f_strobe(logic [1:0] sz, logic [1:0] a);
        if (sz == 2'd0) return 4'(1 << a);
        if (sz == 2'd1) return (a >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] f_wdata(logic [1:0] sz, logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] f_load(logic [1:0] sz, logic [1:0] a,
                                           bit sgn, logic [31:0] w);
        int          sh;
        int          wd;
        logic [31:0] m;
        logic [31:0] v;
        if (sz == 2'd0) begin sh = a * 8; wd = 8; end
        else if (sz == 2'd1) begin sh = (a / 2) * 16; wd = 16; end
        else return w;
        m = (32'd1 << wd) - 32'd1;
        v = (w >> sh) & m;
        if (sgn && v[wd-1]) v = v | ~m;
        return v;
    endfunction

    bit          m_busy = 0;
    bit          m_resp = 0;
    txn_t        t = '{0, 0, 32'h0, 2'd0, 0, 32'h0};
    logic [31:0] m_word = 32'h0;
    int          m_streak = 0;
    logic        s_load = 0, s_store = 0, s_sgn = 0, s_ready = 0;
    logic [31:0] s_addr = 0, s_fa = 0, s_sdata = 0, s_rdata = 0;
    logic [1:0]  s_size = 0;

    function automatic bit data_wins(bit req, int streak);
`ifdef BUS_ARB_FAIR_EN
        return req && (streak < 4);
`else
        return req;
`endif
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy   <= 0;
            m_resp   <= 0;
            m_streak <= 0;
        end else if (m_resp) begin
            m_resp <= 0;
        end else if (m_busy) begin
            if (s_ready) begin
                m_word <= s_rdata;
                m_busy <= 0;
                m_resp <= 1;
            end
        end else begin
            m_busy <= 1;
            if (data_wins(s_load | s_store, m_streak)) begin
                t <= '{1, s_store, s_addr, s_size, s_sgn, s_sdata};
                m_streak <= m_streak + 1;
            end else begin
                t <= '{0, 0, s_fa, 2'd2, 0, 32'h0};
                m_streak <= 0;
            end
        end
    end

    always @(negedge clk) begin
        s_load  <= mem_load;
        s_store <= mem_store;
        s_addr  <= mem_address;
        s_size  <= mem_size;
        s_sgn   <= mem_signed;
        s_sdata <= mem_store_data;
        s_fa    <= fetch_address;
        s_ready <= ext.ready;
        s_rdata <= ext.read_data;
        chk("m_valid", 32'(ext.valid), 32'(m_busy));
        if (m_busy) begin
            chk("m_addr", ext.address, t.addr & ~32'h3);
            chk("m_write", 32'(ext.write), 32'(t.store));
            chk("m_strobe", 32'(ext.strobe),
                t.store ? 32'(f_strobe(t.size, t.addr[1:0])) : 32'h0);
            if (t.store)
                chk("m_wdata", ext.write_data, f_wdata(t.size, t.sdata));
        end
        chk("m_mem_ready", 32'(mem_ready),
            32'(!(mem_load | mem_store) || (m_resp && t.data)));
        chk("m_fetch_ready", 32'(fetch_ready),
            32'(m_resp && !t.data && (t.addr == fetch_address)));
        if (m_resp && !t.data && (t.addr == fetch_address))
            chk("m_fetch_data", fetch_data, m_word);
        if (m_resp && t.data && !t.store)
            chk("m_load_data", mem_load_data,
                f_load(t.size, t.addr[1:0], t.sgn, m_word));
    end

    // ---------------- directed sequences ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_fetch(input string nm);
        int n = 0;
        @(negedge clk);
        while (!fetch_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(fetch_ready), 32'h1);
    endtask

    initial begin
        int  pulses;
        bit  found;
        bit  pv;
        int  g;
        int  n;
        logic [31:0] ga [10];

        @(negedge clk);
        chk("rst_valid", 32'(ext.valid), 32'h0);
        chk("rst_addr", ext.address, 32'h0);
        chk("rst_strobe", 32'(ext.strobe), 32'h0);
        chk("rst_write", 32'(ext.write), 32'h0);
        chk("rst_wdata", ext.write_data, 32'h0);
        chk("rst_fetch_data", fetch_data, 32'h0);
        chk("rst_load_data", mem_load_data, 32'h0);
        chk("rst_mem_ready", 32'(mem_ready), 32'h1);
        mem_load = 1;
        #1 chk("rst_mem_ready_req", 32'(mem_ready), 32'h0);
        mem_load = 0;

        // 1: fetch latency
        cyc(); reset = 1;
        @(negedge clk);
        chk("t1_idle_valid", 32'(ext.valid), 32'h0);
        cyc(); @(negedge clk);
        chk("t1_valid", 32'(ext.valid), 32'h1);
        chk("t1_addr", ext.address, 32'h100);
        cyc(); @(negedge clk);
        chk("t1_fready", 32'(fetch_ready), 32'h1);
        chk("t1_fdata", fetch_data, 32'hDEADBEEF);

        // 2: data beats fetch
        cyc();
        mem_address = 32'h300; mem_size = 2'd2; mem_load = 1;
        rd_word = 32'h11223344;
        @(negedge clk);
        chk("t2_mr_low", 32'(mem_ready), 32'h0);
        cyc(); @(negedge clk);
        chk("t2_daddr", ext.address, 32'h300);
        cyc(); @(negedge clk);
        chk("t2_mr_pulse", 32'(mem_ready), 32'h1);
        chk("t2_ldata", mem_load_data, 32'h11223344);
        cyc(); mem_load = 0;
        cyc(); @(negedge clk);
        chk("t2_faddr", ext.address, 32'h100);

        // 3: signed byte, unsigned half
        sync_fetch("t3_sync_a");
        cyc();
        mem_address = 32'h203; mem_size = 2'd0; mem_signed = 1;
        mem_load = 1; rd_word = 32'h80FFFFFF;
        cyc(); cyc(); @(negedge clk);
        chk("t3_byte_rdy", 32'(mem_ready), 32'h1);
        chk("t3_byte", mem_load_data, 32'hFFFFFF80);
        cyc(); mem_load = 0;
        sync_fetch("t3_sync_b");
        cyc();
        mem_address = 32'h202; mem_size = 2'd1; mem_signed = 0;
        mem_load = 1; rd_word = 32'h80011234;
        cyc(); cyc(); @(negedge clk);
        chk("t3_half", mem_load_data, 32'h00008001);
        cyc(); mem_load = 0;

        // 4: store half
        sync_fetch("t4_sync");
        cyc();
        mem_address = 32'h206; mem_size = 2'd1;
        mem_store_data = 32'h1234ABCD; mem_store = 1;
        cyc(); @(negedge clk);
        chk("t4_addr", ext.address, 32'h204);
        chk("t4_strobe", 32'(ext.strobe), 32'hC);
        chk("t4_wdata", ext.write_data, 32'hABCDABCD);
        chk("t4_write", 32'(ext.write), 32'h1);
        cyc(); @(negedge clk);
        chk("t4_ready", 32'(mem_ready), 32'h1);
        cyc(); mem_store = 0;

        // 5: redirect during a slow fetch
        sync_fetch("t5_sync");
        cyc(); fetch_address = 32'h40; wait_n = 3;
        cyc(); @(negedge clk);
        chk("t5_addr40", ext.address, 32'h40);
        cyc(); fetch_address = 32'h80;
        pulses = 0; found = 0; n = 0;
        while (!found && n < 20) begin
            @(negedge clk);
            if (fetch_ready) pulses++;
            if (ext.valid && ext.address == 32'h80) found = 1;
            n++;
        end
        chk("t5_no_stale", 32'(pulses), 32'h0);
        chk("t5_reissue", 32'(found), 32'h1);
        sync_fetch("t5_f80");
        cyc(); wait_n = 0;

        // 6: reset during BUS
        sync_fetch("t6_sync");
        cyc(); wait_n = 5;
        cyc(); @(negedge clk);
        chk("t6_in_bus", 32'(ext.valid), 32'h1);
        #2 reset = 0;
        #1 chk("t6_drop", 32'(ext.valid), 32'h0);
        chk("t6_no_fr", 32'(fetch_ready), 32'h0);
        cyc(); cyc();
        wait_n = 0; reset = 1;

        // fairness / strict priority under constant load
        fetch_address = 32'h100;
        sync_fetch("t7_sync");
        cyc();
        mem_address = 32'h500; mem_size = 2'd2; mem_load = 1;
        pv = 0; g = 0; n = 0;
        while (g < 10 && n < 200) begin
            @(negedge clk);
            if (ext.valid && !pv) begin
                ga[g] = ext.address;
                g++;
            end
            pv = ext.valid;
            n++;
        end
        chk("t7_grants", 32'(g), 32'd10);
        for (int i = 0; i < 10; i++) begin
`ifdef BUS_ARB_FAIR_EN
            chk("t7_order", ga[i], (i % 5 == 4) ? 32'h100 : 32'h500);
`else
            chk("t7_order", ga[i], 32'h500);
`endif
        end
        cyc(); mem_load = 0;
        repeat (6) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
